// File: rtl/operand_entry_controller.sv
// operand_entry_controller
//
// Converts the board's slide switches and push-buttons into a handshaked
// stream of 16-bit operand words for the FPMAC pipeline. It also produces
// the init/done/display_value signals for the seven-segment display path.
//
// Ports:
//   clock_100Mhz   in   1   system clock; all logic runs on its rising edge
//   reset          in   1   asynchronous, active-low reset
//   btn_enter      in   1   raw enter button (asynchronous, bouncing)
//   btn_clear      in   1   raw clear button (asynchronous, bouncing)
//   sw             in  16   slide switches holding the operand value
//   data_ready     in   1   FPMAC accepts a word
//   data_valid     out  1   data_out holds a word
//   data_out       out 16   captured operand
//   operand_index  out  4   index of the word being collected or sent
//   init           out  1   high while in INIT
//   done           out  1   high while in DONE
//   display_value  out 16   value for the display controller
//
// Also contains operand_entry_button: a 2-flop synchronizer, a debouncer
// and a rising-edge pulse generator for one push-button.

module operand_entry_button #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      // Stage p0/p1: metastability synchronizer
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Debounce: the level follows sync_p1 only after the difference has
      // been seen on DEBOUNCE_CYCLES consecutive edges
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Rising edge of the debounced level only
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

module operand_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_OPERANDS    = 4
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic [15:0] sw,
  input  logic        data_ready,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [3:0]  operand_index,
  output logic        init,
  output logic        done,
  output logic [15:0] display_value
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_OPERANDS - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] index_n;
  logic       capture;
  logic       enter_p;
  logic       clear_p;

  operand_entry_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .raw          (btn_enter),
    .pulse        (enter_p)
  );

  operand_entry_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .raw          (btn_clear),
    .pulse        (clear_p)
  );

  // Clear outranks every other event, including a same-cycle handshake,
  // so the word in flight is treated as not delivered.
  always_comb begin
    state_n = state;
    index_n = operand_index;
    capture = 1'b0;
    if (clear_p) begin
      state_n = ST_INIT;
      index_n = 4'd0;
    end else begin
      case (state)
        ST_INIT: begin
          index_n = 4'd0;
          if (enter_p) state_n = ST_COLLECT;
        end
        ST_COLLECT: begin
          if (enter_p) begin
            state_n = ST_SEND;
            capture = 1'b1;
          end
        end
        ST_SEND: begin
          if (data_valid && data_ready) begin
            if (operand_index == LAST_IDX) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_COLLECT;
              index_n = operand_index + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Flag outputs are decoded from the next state so they change on the
  // same edge as the transition itself.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state         <= ST_INIT;
      operand_index <= 4'd0;
      data_valid    <= 1'b0;
      data_out      <= 16'h0000;
      init          <= 1'b1;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      operand_index <= index_n;
      data_valid    <= (state_n == ST_SEND);
      init          <= (state_n == ST_INIT);
      done          <= (state_n == ST_DONE);
      if (capture) data_out <= sw;
    end
  end

  // COLLECT shows the live switches so the user sees what will be captured.
  always_comb begin
    case (state)
      ST_INIT:    display_value = 16'h0000;
      ST_COLLECT: display_value = sw;
      default:    display_value = data_out;
    endcase
  end

endmodule
